route_scheduler: RTL and testbench
==================================

Name: route_scheduler

Overview:
- Registered arbiter and scheduler for the router crossbar and outports.
- Accepts the {x_hit, y_hit, request} bundles from the north, east and PE inports and decodes each into a dimension-order route.
- Arbitrates each output (south, west, pe) between its requesters, with round-robin fairness between network inputs and a starvation guard for PE injection.
- Drives the crossbar mux controls and outport toggles, plus per-input acks so requesters hold their flit until it is accepted.

Parameters:
PE_STARVE_LIMIT, 4, consecutive lost arbitrations after which a PE request wins over network traffic on south/west
CNT_W, 3, starvation counter width; PE_STARVE_LIMIT must be < 2^CNT_W and >= 1

Ports:
clka  input  1  clock, all state on rising edge
rsta  input  1  reset, asynchronous, active-low
north_request_bundle  input  3  [2] x_hit, [1] y_hit, [0] request
east_request_bundle  input  3  same format
pe_request_bundle  input  3  same format
south_cfg_bundle  output  3  [2:1] mux select, [0] toggle
west_cfg_bundle  output  3  [2:1] mux select, [0] toggle
pe_cfg_bundle  output  2  [1] select (0 north, 1 east), [0] toggle
north_ack_dout  output  1  north flit accepted (1-cycle pulse)
east_ack_dout  output  1  east flit accepted (1-cycle pulse)
r2pe_ack  output  1  PE flit accepted (1-cycle pulse)
self_drop_dout  output  1  PE flit addressed to the local node was discarded (1-cycle pulse)

Behaviour:
- Reset (rsta=0, async): all outputs 0, all round-robin pointers 0 (north first), starvation counter 0. Reset applied mid-operation discards any pending decision; requesters keep requesting and re-arbitrate from reset state.
- An input is valid in cycle t when request=1 and its ack output is not high in cycle t. This masks the ack cycle so a held request is not granted twice.
- Route decode of a valid input:
  - x_hit & y_hit -> PE output.
  - x_hit & !y_hit -> south.
  - !x_hit -> west.
  - Each input targets exactly one output per cycle.
- South/west mux select encoding: 00 north, 01 east, 10 PE; 11 is never driven.
- PE output arbitration: candidates are north and east, chosen by 1-bit pointer pe_ptr (0 prefers north). After a grant, the pointer points to the non-winner.
- South output arbitration, if PE and at least one network input request it:
  - starve_cnt == PE_STARVE_LIMIT: PE wins.
  - Otherwise: the network input chosen by south_ptr wins.
  - The pointer updates only on a network grant (to the non-winner).
- West output arbitration: same rules, with its own pointer.
- Single requester on any output: always granted.
- PE addressed to the local node (PE bundle 111):
  - Treated as always granted: r2pe_ack=1 and self_drop_dout=1.
  - No output toggles and starve_cnt is cleared.
  - Subject to the same ack-cycle mask.
- starve_cnt:
  - Cleared when PE is granted or PE is not valid.
  - Incremented (saturating at PE_STARVE_LIMIT) in each cycle PE is valid for south/west and loses.
- Latency: decisions are computed combinationally from cycle-t inputs and registered. Cfg, toggle and acks all appear in cycle t+1 together, for exactly one cycle.
- Without a grant on an output, its toggle is 0 and its mux select bits hold their last value.
- Simultaneous grants on all three outputs in one cycle are legal. Example: north->pe, east->south, PE->west.
- Requesters must drop or replace request in the cycle after seeing ack. A request still high in t+2 is a new flit.

Test Plan:
- Reset: hold rsta=0 with random requests -> every output 0. Release rsta -> first grant uses north priority.
- North 3'b101 alone at t, dropped at t+2 -> t+1: south_cfg=3'b001 and north_ack=1. t+2: south toggle=0, north_ack=0, south_cfg[2:1] holds 00.
- North 3'b111 and east 3'b111 held, each re-presented after its ack -> pe_cfg alternates 2'b01 (north), 2'b11 (east), 2'b01, ... with the matching acks; never two consecutive acks to the same input.
- PE_STARVE_LIMIT=4: north, east and PE all held at 3'b001 (west), each re-presented after ack.
  - First four west grants alternate north/east; starve_cnt reaches 4.
  - Fifth grant: west_cfg=3'b101 and r2pe_ack=1; starve_cnt returns to 0.
- PE bundle 3'b111 -> next cycle r2pe_ack=1 and self_drop_dout=1, all three toggles 0.
- rsta pulsed low while starve_cnt=3 with grants pending -> outputs clear immediately (asynchronously). After release, PE needs four further lost arbitrations before it wins.

Source files
------------

// File: rtl/route_scheduler.sv
// Purpose: registered arbiter/scheduler driving crossbar mux selects, outport toggles and inport acks.
// Latency: decisions from cycle-t requests appear on cfg/toggle/ack outputs in cycle t+1 for one cycle.
// Backpressure: a requester holds its flit until acked; the ack cycle masks the request so it is not granted twice.
module route_scheduler #(
    parameter int PE_STARVE_LIMIT = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clka,
    input  logic       rsta,
    input  logic [2:0] north_request_bundle,
    input  logic [2:0] east_request_bundle,
    input  logic [2:0] pe_request_bundle,
    output logic [2:0] south_cfg_bundle,
    output logic [2:0] west_cfg_bundle,
    output logic [1:0] pe_cfg_bundle,
    output logic       north_ack_dout,
    output logic       east_ack_dout,
    output logic       r2pe_ack,
    output logic       self_drop_dout
);

    // Mux select codes for the south/west outports.
    localparam logic [1:0] SEL_NORTH = 2'b00;
    localparam logic [1:0] SEL_EAST  = 2'b01;
    localparam logic [1:0] SEL_PE    = 2'b10;

    // Round-robin pointers: 0 prefers north, 1 prefers east.
    logic             pe_ptr;
    logic             south_ptr;
    logic             west_ptr;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;

    logic n_vld, e_vld, p_vld;
    logic n_to_pe, n_to_s, n_to_w;
    logic e_to_pe, e_to_s, e_to_w;
    logic p_self, p_to_s, p_to_w;
    logic starve_lim;
    logic pe_won, pe_lost;

    // Grant vectors: {pe, east, north} for south/west, {east, north} for the PE outport.
    logic [2:0] s_gnt;
    logic [2:0] w_gnt;
    logic [1:0] pe_gnt;

    // Three-way arbitration for an outport that both network inputs and the PE can target.
    function automatic logic [2:0] arb3(input logic n, input logic e, input logic p,
                                        input logic ptr, input logic lim);
        logic [2:0] g;
        logic       net_n;
        logic       net_e;
        net_n = n & (~e | ~ptr);
        net_e = e & (~n | ptr);
        if (p && (!(n || e) || lim)) begin
            g = 3'b100;
        end else begin
            g = {1'b0, net_e, net_n};
        end
        return g;
    endfunction

    // A request already acked this cycle is the old flit and must not be granted again.
    assign n_vld = north_request_bundle[0] & ~north_ack_dout;
    assign e_vld = east_request_bundle[0]  & ~east_ack_dout;
    assign p_vld = pe_request_bundle[0]    & ~r2pe_ack;

    // Dimension-order decode: x&y local, x&!y south, !x west.
    assign n_to_pe = n_vld &  north_request_bundle[2] &  north_request_bundle[1];
    assign n_to_s  = n_vld &  north_request_bundle[2] & ~north_request_bundle[1];
    assign n_to_w  = n_vld & ~north_request_bundle[2];
    assign e_to_pe = e_vld &  east_request_bundle[2]  &  east_request_bundle[1];
    assign e_to_s  = e_vld &  east_request_bundle[2]  & ~east_request_bundle[1];
    assign e_to_w  = e_vld & ~east_request_bundle[2];
    assign p_self  = p_vld &  pe_request_bundle[2]    &  pe_request_bundle[1];
    assign p_to_s  = p_vld &  pe_request_bundle[2]    & ~pe_request_bundle[1];
    assign p_to_w  = p_vld & ~pe_request_bundle[2];

    assign starve_lim = (starve_cnt == CNT_W'(PE_STARVE_LIMIT));

    // Per-outport grant decisions and the next starvation count.
    always_comb begin
        s_gnt      = arb3(n_to_s, e_to_s, p_to_s, south_ptr, starve_lim);
        w_gnt      = arb3(n_to_w, e_to_w, p_to_w, west_ptr, starve_lim);
        pe_gnt     = {e_to_pe & (~n_to_pe | pe_ptr), n_to_pe & (~e_to_pe | ~pe_ptr)};
        pe_won     = s_gnt[2] | w_gnt[2] | p_self;
        pe_lost    = (p_to_s & ~s_gnt[2]) | (p_to_w & ~w_gnt[2]);
        starve_nxt = '0;
        if (p_vld && !pe_won && pe_lost) begin
            starve_nxt = starve_lim ? starve_cnt : starve_cnt + CNT_W'(1);
        end
    end

    // Register outport configuration, toggles and acks; selects hold when an outport is idle.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            south_cfg_bundle <= '0;
            west_cfg_bundle  <= '0;
            pe_cfg_bundle    <= '0;
            north_ack_dout   <= 1'b0;
            east_ack_dout    <= 1'b0;
            r2pe_ack         <= 1'b0;
            self_drop_dout   <= 1'b0;
        end else begin
            south_cfg_bundle[0] <= |s_gnt;
            if (|s_gnt) begin
                south_cfg_bundle[2:1] <= s_gnt[2] ? SEL_PE : (s_gnt[1] ? SEL_EAST : SEL_NORTH);
            end
            west_cfg_bundle[0] <= |w_gnt;
            if (|w_gnt) begin
                west_cfg_bundle[2:1] <= w_gnt[2] ? SEL_PE : (w_gnt[1] ? SEL_EAST : SEL_NORTH);
            end
            pe_cfg_bundle[0] <= |pe_gnt;
            if (|pe_gnt) begin
                pe_cfg_bundle[1] <= pe_gnt[1];
            end
            north_ack_dout <= s_gnt[0] | w_gnt[0] | pe_gnt[0];
            east_ack_dout  <= s_gnt[1] | w_gnt[1] | pe_gnt[1];
            r2pe_ack       <= pe_won;
            self_drop_dout <= p_self;
        end
    end

    // Arbitration state: pointers move to the non-winner after a network grant.
    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            pe_ptr     <= 1'b0;
            south_ptr  <= 1'b0;
            west_ptr   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (|pe_gnt) begin
                pe_ptr <= pe_gnt[0];
            end
            if (|s_gnt[1:0]) begin
                south_ptr <= s_gnt[0];
            end
            if (|w_gnt[1:0]) begin
                west_ptr <= w_gnt[0];
            end
            starve_cnt <= starve_nxt;
        end
    end

endmodule

// File: tb/tb_route_scheduler.sv
// Purpose: self-checking bench for route_scheduler: directed table, async-reset sequence, random vs model.
// Latency: every applied cycle is checked one clock later, sampled 1 time unit after the rising edge.
// Backpressure: stimulus is free-running; the model applies the ack-cycle mask itself.
module tb_route_scheduler;

    localparam int LIMIT = 4;
    localparam int SOUTH = 0;
    localparam int WEST  = 1;
    localparam int PEOUT = 2;
    localparam int SELF  = 3;
    localparam int NONE  = -1;

    logic       clka = 1'b0;
    logic       rsta = 1'b1;
    logic [2:0] north_request_bundle = '0;
    logic [2:0] east_request_bundle  = '0;
    logic [2:0] pe_request_bundle    = '0;
    logic [2:0] south_cfg_bundle;
    logic [2:0] west_cfg_bundle;
    logic [1:0] pe_cfg_bundle;
    logic       north_ack_dout;
    logic       east_ack_dout;
    logic       r2pe_ack;
    logic       self_drop_dout;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clka = ~clka;

    route_scheduler #(.PE_STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clka                 (clka),
        .rsta                 (rsta),
        .north_request_bundle (north_request_bundle),
        .east_request_bundle  (east_request_bundle),
        .pe_request_bundle    (pe_request_bundle),
        .south_cfg_bundle     (south_cfg_bundle),
        .west_cfg_bundle      (west_cfg_bundle),
        .pe_cfg_bundle        (pe_cfg_bundle),
        .north_ack_dout       (north_ack_dout),
        .east_ack_dout        (east_ack_dout),
        .r2pe_ack             (r2pe_ack),
        .self_drop_dout       (self_drop_dout)
    );

    // Reference model state: inputs indexed 0 north, 1 east, 2 PE; outports 0 south, 1 west, 2 pe.
    int       m_ptr [3];
    int       m_sel [3];
    int       m_tgt [3];
    int       m_starve;
    bit       m_ack [3];
    bit [2:0] x_s;
    bit [2:0] x_w;
    bit [1:0] x_pe;
    bit       x_ack [3];
    bit       x_drop;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ptr[i] = 0;
            m_sel[i] = 0;
            m_ack[i] = 1'b0;
            x_ack[i] = 1'b0;
        end
        m_starve = 0;
        x_s = '0;
        x_w = '0;
        x_pe = '0;
        x_drop = 1'b0;
    endtask

    // Pick the winner for one outport; PE beats network traffic only when alone or starved.
    task automatic arb(input int o, output int w);
        int cand [$];
        w = NONE;
        for (int i = 0; i < 2; i++) if (m_tgt[i] == o) cand.push_back(i);
        if (m_tgt[2] == o && (cand.size() == 0 || m_starve == LIMIT)) w = 2;
        else if (cand.size() == 1) w = cand[0];
        else if (cand.size() == 2) w = m_ptr[o];
        if (w == 0 || w == 1) m_ptr[o] = 1 - w;
    endtask

    task automatic model_eval(input logic [2:0] nb, input logic [2:0] eb, input logic [2:0] pb);
        logic [2:0] b [3];
        int         w [3];
        b[0] = nb;
        b[1] = eb;
        b[2] = pb;
        for (int i = 0; i < 3; i++) begin
            if (!b[i][0] || m_ack[i]) m_tgt[i] = NONE;
            else if (b[i][2] && b[i][1]) m_tgt[i] = (i == 2) ? SELF : PEOUT;
            else if (b[i][2]) m_tgt[i] = SOUTH;
            else m_tgt[i] = WEST;
        end
        for (int o = 0; o < 3; o++) arb(o, w[o]);
        for (int i = 0; i < 3; i++) x_ack[i] = 1'b0;
        for (int o = 0; o < 3; o++) begin
            if (w[o] >= 0) begin
                x_ack[w[o]] = 1'b1;
                m_sel[o] = w[o];
            end
        end
        x_drop = (m_tgt[2] == SELF);
        if (x_drop) x_ack[2] = 1'b1;
        if (m_tgt[2] == NONE || x_ack[2]) m_starve = 0;
        else if (m_starve < LIMIT) m_starve = m_starve + 1;
        x_s  = {2'(m_sel[0]), (w[0] >= 0) ? 1'b1 : 1'b0};
        x_w  = {2'(m_sel[1]), (w[1] >= 0) ? 1'b1 : 1'b0};
        x_pe = {1'(m_sel[2]), (w[2] >= 0) ? 1'b1 : 1'b0};
        for (int i = 0; i < 3; i++) m_ack[i] = x_ack[i];
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input bit [2:0] s, input bit [2:0] w, input bit [1:0] pc,
                             input bit na, input bit ea, input bit pa, input bit dr);
        chk({tag, ".south_cfg"}, 8'(south_cfg_bundle), 8'(s));
        chk({tag, ".west_cfg"},  8'(west_cfg_bundle),  8'(w));
        chk({tag, ".pe_cfg"},    8'(pe_cfg_bundle),    8'(pc));
        chk({tag, ".north_ack"}, 8'(north_ack_dout),   8'(na));
        chk({tag, ".east_ack"},  8'(east_ack_dout),    8'(ea));
        chk({tag, ".r2pe_ack"},  8'(r2pe_ack),         8'(pa));
        chk({tag, ".self_drop"}, 8'(self_drop_dout),   8'(dr));
    endtask

    // Drive one cycle of requests, advance the model, and land 1 unit after the capturing edge.
    task automatic step(input logic [2:0] nb, input logic [2:0] eb, input logic [2:0] pb);
        north_request_bundle = nb;
        east_request_bundle  = eb;
        pe_request_bundle    = pb;
        model_eval(nb, eb, pb);
        @(posedge clka);
        #1;
    endtask

    task automatic step_model(input string tag, input logic [2:0] nb, input logic [2:0] eb, input logic [2:0] pb);
        step(nb, eb, pb);
        check_all(tag, x_s, x_w, x_pe, x_ack[0], x_ack[1], x_ack[2], x_drop);
    endtask

    typedef struct {
        bit [2:0] n, e, p;
        bit [2:0] s, w;
        bit [1:0] pc;
        bit       na, ea, pa, dr;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // n,e,p requests -> expected south_cfg, west_cfg, pe_cfg, north/east/pe acks, self_drop
        tbl[0]  = '{3'b101, 3'b000, 3'b000, 3'b001, 3'b000, 2'b00, 1, 0, 0, 0};
        tbl[1]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 2'b00, 0, 0, 0, 0};
        tbl[2]  = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 2'b01, 1, 0, 0, 0};
        tbl[3]  = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 2'b11, 0, 1, 0, 0};
        tbl[4]  = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 2'b01, 1, 0, 0, 0};
        tbl[5]  = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 2'b11, 0, 1, 0, 0};
        tbl[6]  = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 2'b10, 0, 0, 1, 1};
        tbl[7]  = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 2'b10, 0, 0, 0, 0};
        tbl[8]  = '{3'b111, 3'b101, 3'b001, 3'b011, 3'b101, 2'b01, 1, 1, 1, 0};
        tbl[9]  = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 2'b00, 0, 0, 0, 0};
        tbl[10] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 2'b00, 1, 0, 0, 0};
        tbl[11] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b011, 2'b00, 0, 1, 0, 0};
        tbl[12] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 2'b00, 1, 0, 0, 0};
        tbl[13] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b011, 2'b00, 0, 1, 0, 0};
        tbl[14] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b101, 2'b00, 0, 0, 1, 0};
        tbl[15] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 2'b00, 1, 0, 0, 0};

        model_reset();

        // Reset held with random requests: every output stays 0.
        #2 rsta = 1'b0;
        for (int i = 0; i < 4; i++) begin
            north_request_bundle = 3'($urandom_range(0, 7));
            east_request_bundle  = 3'($urandom_range(0, 7));
            pe_request_bundle    = 3'($urandom_range(0, 7));
            @(posedge clka);
            #1;
            check_all($sformatf("in_reset%0d", i), 3'b000, 3'b000, 2'b00, 0, 0, 0, 0);
        end
        rsta = 1'b1;
        model_reset();

        // Directed table from reset state.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].n, tbl[i].e, tbl[i].p);
            check_all($sformatf("vec%0d", i), tbl[i].s, tbl[i].w, tbl[i].pc,
                      tbl[i].na, tbl[i].ea, tbl[i].pa, tbl[i].dr);
        end

        // Build starvation up to 3 with all three inputs contending for west.
        for (int i = 0; i < 3; i++) step_model($sformatf("pre_rst%0d", i), 3'b001, 3'b001, 3'b001);

        // Asynchronous reset mid-cycle with requests still pending.
        #3 rsta = 1'b0;
        #1;
        check_all("async_rst", 3'b000, 3'b000, 2'b00, 0, 0, 0, 0);
        @(posedge clka);
        #1;
        check_all("rst_hold", 3'b000, 3'b000, 2'b00, 0, 0, 0, 0);
        rsta = 1'b1;
        model_reset();

        // After reset the PE must lose four more times before it wins west.
        for (int i = 0; i < 5; i++) begin
            step_model($sformatf("post_rst%0d", i), 3'b001, 3'b001, 3'b001);
            chk($sformatf("post_rst%0d.pe_wins", i), 8'(r2pe_ack), (i == 4) ? 8'd1 : 8'd0);
            chk($sformatf("post_rst%0d.west_sel", i), 8'(west_cfg_bundle),
                (i == 4) ? 8'h5 : ((i % 2 == 0) ? 8'h1 : 8'h3));
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step_model($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
